// File: rtl/signextend_lane.sv
// -----------------------------------------------------------------------------
// signextend_lane
//   Combinational single-lane sign extender. Widens one two's-complement field
//   of IN_W bits to OUT_W bits by replicating its sign bit into the new MSBs.
//
// Parameters
//   IN_W   width of the input field (>= 1)
//   OUT_W  width of the output field (>= IN_W)
//
// Ports
//   din    input  [IN_W-1:0]   signed input field
//   dout   output [OUT_W-1:0]  sign-extended result
// -----------------------------------------------------------------------------
module signextend_lane #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  localparam int EXT_W = OUT_W - IN_W;

  generate
    if (EXT_W < 0) begin : g_bad_width
      $error("signextend_lane: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
      assign dout = '0;
    end else if (EXT_W == 0) begin : g_copy
      // Equal widths: a zero-count replication is not legal on its own, so the
      // field is passed through unchanged.
      assign dout = din;
    end else begin : g_extend
      assign dout = {{EXT_W{din[IN_W-1]}}, din};
    end
  endgenerate

endmodule

// File: rtl/signextend.sv
// -----------------------------------------------------------------------------
// signextend
//   Parallel, pipelined sign extender. DEPTH packed lanes of DATA_WIDTH_IN bits
//   are each widened to DATA_WIDTH_OUT bits and presented on dataOut after
//   DELAY clock cycles. With DELAY = 0 the block is purely combinational.
//
// Parameters
//   DATA_WIDTH_IN   width of each input lane (>= 1)
//   DEPTH           number of independent lanes (>= 1)
//   DATA_WIDTH_OUT  width of each output lane (>= DATA_WIDTH_IN)
//   DELAY           pipeline latency in cycles (>= 0)
//
// Ports
//   clk      input   rising-edge clock
//   rst      input   synchronous reset, active-high; clears every stage
//   en_n     input   active-low enable: 0 = advance, 1 = hold all stages
//   dataIn   input   [DATA_WIDTH_IN*DEPTH-1:0]  packed input lanes
//   dataOut  output  [DATA_WIDTH_OUT*DEPTH-1:0] packed output lanes
// -----------------------------------------------------------------------------
module signextend #(
  parameter int DATA_WIDTH_IN  = 4,
  parameter int DEPTH          = 2,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int DELAY          = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_n,
  input  logic [DATA_WIDTH_IN*DEPTH-1:0]  dataIn,
  output logic [DATA_WIDTH_OUT*DEPTH-1:0] dataOut
);

  localparam int BUS_W = DATA_WIDTH_OUT * DEPTH;

  generate
    if (DATA_WIDTH_OUT < DATA_WIDTH_IN) begin : g_param_check
      $error("signextend: DATA_WIDTH_OUT (%0d) must be >= DATA_WIDTH_IN (%0d)",
             DATA_WIDTH_OUT, DATA_WIDTH_IN);
    end
    if (DELAY < 0) begin : g_delay_check
      $error("signextend: DELAY (%0d) must be >= 0", DELAY);
    end
  endgenerate

  // Extension happens combinationally ahead of the first register stage.
  logic [BUS_W-1:0] ext;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
      signextend_lane #(
        .IN_W  (DATA_WIDTH_IN),
        .OUT_W (DATA_WIDTH_OUT)
      ) u_lane (
        .din  (dataIn[i*DATA_WIDTH_IN +: DATA_WIDTH_IN]),
        .dout (ext[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT])
      );
    end
  endgenerate

  generate
    if (DELAY <= 0) begin : g_comb
      // No registers: clk, rst and en_n are intentionally ignored.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, en_n};
      assign dataOut     = ext;
    end else begin : g_pipe
      logic [BUS_W-1:0] stage [DELAY];

      // NOTE: every stage is cleared on reset, even though it is an array,
      // because the output must read zero until valid data has propagated.
      // Stages are written with non-blocking assignments so each one loads
      // its predecessor's pre-edge value and the chain shifts by exactly one.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < DELAY; s++) stage[s] <= '0;
        end else if (!en_n) begin
          stage[0] <= ext;
          for (int s = 1; s < DELAY; s++) stage[s] <= stage[s-1];
        end
      end

      assign dataOut = stage[DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_signextend.sv
// -----------------------------------------------------------------------------
// tb_signextend
//   Self-checking bench for signextend. Three instances share clk/rst/en_n:
//     u_d1 : default parameters (4->8 bits, 2 lanes, DELAY=1)
//     u_d3 : DELAY=3, otherwise default
//     u_d0 : DELAY=0, 4 lanes, 3->5 bits (combinational)
//   Expected values come from an arithmetic reference (interpret each lane as a
//   signed integer, re-encode it in the wider field) and, for the pipelined
//   instances, from a history of accepted samples since the last reset.
// -----------------------------------------------------------------------------
module tb_signextend;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_n = 1'b0;
  logic [7:0]  d1 = '0;
  logic [7:0]  d3 = '0;
  logic [11:0] d0 = '0;
  logic [15:0] out1;
  logic [15:0] out3;
  logic [19:0] out0;

  int n_checks = 0;
  int n_fail   = 0;

  // Accepted (already extended) samples since the last reset.
  logic [63:0] hist1 [$];
  logic [63:0] hist3 [$];

  always #5 clk = ~clk;

  signextend #(
    .DATA_WIDTH_IN(4), .DEPTH(2), .DATA_WIDTH_OUT(8), .DELAY(1)
  ) u_d1 (
    .clk(clk), .rst(rst), .en_n(en_n), .dataIn(d1), .dataOut(out1)
  );

  signextend #(
    .DATA_WIDTH_IN(4), .DEPTH(2), .DATA_WIDTH_OUT(8), .DELAY(3)
  ) u_d3 (
    .clk(clk), .rst(rst), .en_n(en_n), .dataIn(d3), .dataOut(out3)
  );

  signextend #(
    .DATA_WIDTH_IN(3), .DEPTH(4), .DATA_WIDTH_OUT(5), .DELAY(0)
  ) u_d0 (
    .clk(clk), .rst(rst), .en_n(en_n), .dataIn(d0), .dataOut(out0)
  );

  // Reference: each lane read as a signed integer, then written back modulo
  // 2^wout into its output slot.
  function automatic logic [63:0] ref_ext(input logic [63:0] din, input int win,
                                          input int depth, input int wout);
    logic [63:0] res = '0;
    for (int l = 0; l < depth; l++) begin
      longint v = longint'((din >> (l * win)) & ((64'd1 << win) - 64'd1));
      if (v >= (longint'(1) << (win - 1))) v = v - (longint'(1) << win);
      res |= (64'(v) & ((64'd1 << wout) - 64'd1)) << (l * wout);
    end
    return res;
  endfunction

  function automatic logic [63:0] expect_pipe(input logic [63:0] h [$], input int d);
    if (h.size() >= d) return h[h.size() - d];
    return '0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record what the registers will capture at the coming edge, then advance
  // and sample 1 ns after the edge.
  task automatic step();
    if (rst) begin
      hist1.delete();
      hist3.delete();
    end else if (!en_n) begin
      hist1.push_back(ref_ext(64'(d1), 4, 2, 8));
      hist3.push_back(ref_ext(64'(d3), 4, 2, 8));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_models(input string tag);
    check({tag, "_d1"}, 64'(out1), expect_pipe(hist1, 1));
    check({tag, "_d3"}, 64'(out3), expect_pipe(hist3, 3));
    check({tag, "_d0"}, 64'(out0), ref_ext(64'(d0), 3, 4, 5));
  endtask

  typedef struct {
    logic [7:0]  din;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{din: 8'hA5, exp: 16'hFA05};
    vecs[1] = '{din: 8'h7F, exp: 16'h07FF};
    vecs[2] = '{din: 8'h80, exp: 16'hF800};
    vecs[3] = '{din: 8'h00, exp: 16'h0000};
    vecs[4] = '{din: 8'hFF, exp: 16'hFFFF};

    // Reset state
    #1;
    rst = 1'b1; en_n = 1'b0; d1 = 8'hA5; d3 = 8'h5A;
    step();
    check("reset_d1", 64'(out1), 64'h0);
    check("reset_d3", 64'(out3), 64'h0);
    rst = 1'b0;

    // Table-driven vectors through the DELAY=1 instance
    for (int i = 0; i < 5; i++) begin
      d1 = vecs[i].din;
      step();
      check($sformatf("vec%0d", i), 64'(out1), 64'(vecs[i].exp));
    end

    // Stall: load A5, then hold for three cycles while the input changes
    d1 = 8'hA5;
    step();
    check("stall_load", 64'(out1), 64'hFA05);
    en_n = 1'b1; d1 = 8'h12;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), 64'(out1), 64'hFA05);
    end
    en_n = 1'b0;
    step();
    check("stall_resume", 64'(out1), 64'h0102);

    // Reset priority over enable, then refill after release
    d1 = 8'hA5; d3 = 8'h55;
    rst = 1'b1;
    step();
    check("rst_prio_d1", 64'(out1), 64'h0);
    check("rst_prio_d3", 64'(out3), 64'h0);
    rst = 1'b0;
    step();
    check("rst_release_d1", 64'(out1), 64'hFA05);
    check("rst_release_d3_still0", 64'(out3), 64'h0);
    step();
    check("rst_release2_d3_still0", 64'(out3), 64'h0);

    // DELAY=3 stream: inputs on edges 1..3, outputs on edges 3..5
    rst = 1'b1;
    step();
    rst = 1'b0;
    d3 = 8'h1F;
    step();
    d3 = 8'h8E;
    step();
    d3 = 8'h33;
    step();
    check("d3_edge3", 64'(out3), 64'h01FF);
    d3 = 8'h00;
    step();
    check("d3_edge4", 64'(out3), 64'hF8FE);
    step();
    check("d3_edge5", 64'(out3), 64'h0303);

    // DELAY=0: combinational, unaffected by clk/rst/en_n
    d0 = 12'b100_011_111_000;
    #1;
    check("d0_comb", 64'(out0), 64'(20'b11100_00011_11111_00000));
    rst = 1'b1; en_n = 1'b1;
    step();
    check("d0_under_rst", 64'(out0), 64'(20'b11100_00011_11111_00000));
    d0 = 12'b011_100_001_110;
    #1;
    check("d0_change_under_rst", 64'(out0), 64'(20'b00011_11100_00001_11110));
    rst = 1'b0; en_n = 1'b0;

    // Randomized run against the reference history
    for (int c = 0; c < 300; c++) begin
      rst  = ($urandom_range(0, 99) < 3);
      en_n = ($urandom_range(0, 3) == 0);
      d1   = 8'($urandom);
      d3   = 8'($urandom);
      d0   = 12'($urandom);
      step();
      check_models($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
